// File: rtl/regfile_onehot_wr_if.sv
// Write/read bundle between the WB write-address decoder, the ID read logic and the register file.
interface regfile_onehot_wr_if #(
   parameter int unsigned SELECT_WIDTH = 5,
   parameter int unsigned DATA_WIDTH   = 32
) ();
   localparam int unsigned NumRegs = 2 ** SELECT_WIDTH;

   logic [NumRegs-1:0]      WrOneHot;
   logic [DATA_WIDTH-1:0]   WrData;
   logic [SELECT_WIDTH-1:0] RdAddrA;
   logic [SELECT_WIDTH-1:0] RdAddrB;
   logic                    ClrErr;
   logic [DATA_WIDTH-1:0]   RdDataA;
   logic [DATA_WIDTH-1:0]   RdDataB;
   logic                    WrErr;

   modport master (
      output WrOneHot, WrData, RdAddrA, RdAddrB, ClrErr,
      input  RdDataA, RdDataB, WrErr
   );

   modport slave (
      input  WrOneHot, WrData, RdAddrA, RdAddrB, ClrErr,
      output RdDataA, RdDataB, WrErr
   );
endinterface

// File: rtl/regfile_onehot_wr.sv
// Two-read/one-write register file driven by a one-hot write-enable vector, with
// same-cycle write-to-read bypass, hardwired r0 and a sticky multi-hot error flag.
module regfile_onehot_wr #(
   parameter int unsigned SELECT_WIDTH = 5,
   parameter int unsigned DATA_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_onehot_wr_if.slave    rf
);
   localparam int unsigned NumRegs = 2 ** SELECT_WIDTH;

   logic [DATA_WIDTH-1:0]   regs_q [NumRegs];
   logic [DATA_WIDTH-1:0]   regs_d [NumRegs];
   logic                    wr_err_q;
   logic                    wr_err_d;

   logic                    one_hot_c;
   logic                    multi_hot_c;
   logic                    wr_en_c;
   logic                    bypass_en_c;
   logic [SELECT_WIDTH-1:0] wr_idx_c;
   logic [DATA_WIDTH-1:0]   rd_a_c;
   logic [DATA_WIDTH-1:0]   rd_b_c;

   // Classify the enable vector and encode the selected register.
   always_comb begin
      one_hot_c   = (rf.WrOneHot != '0) &&
                    ((rf.WrOneHot & (rf.WrOneHot - NumRegs'(1))) == '0);
      multi_hot_c = (rf.WrOneHot != '0) && !one_hot_c;
      wr_idx_c    = '0;
      for (int unsigned i = 0; i < NumRegs; i++) begin
         if (rf.WrOneHot[i]) begin
            wr_idx_c = SELECT_WIDTH'(i);
         end
      end
      wr_en_c     = one_hot_c && (wr_idx_c != '0);
      bypass_en_c = wr_en_c && rst_n;
   end

   // Next-state for storage and the sticky error; a multi-hot write beats ClrErr.
   always_comb begin
      regs_d = regs_q;
      if (wr_en_c) begin
         regs_d[wr_idx_c] = rf.WrData;
      end
      wr_err_d = wr_err_q;
      if (multi_hot_c) begin
         wr_err_d = 1'b1;
      end else if (rf.ClrErr) begin
         wr_err_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
         wr_err_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         wr_err_q <= wr_err_d;
      end
   end

   // Read ports: r0 reads zero, a valid write to the same register bypasses storage.
   always_comb begin
      rd_a_c = regs_q[rf.RdAddrA];
      if (rf.RdAddrA == '0) begin
         rd_a_c = '0;
      end else if (bypass_en_c && (rf.RdAddrA == wr_idx_c)) begin
         rd_a_c = rf.WrData;
      end

      rd_b_c = regs_q[rf.RdAddrB];
      if (rf.RdAddrB == '0) begin
         rd_b_c = '0;
      end else if (bypass_en_c && (rf.RdAddrB == wr_idx_c)) begin
         rd_b_c = rf.WrData;
      end
   end

   assign rf.RdDataA = rd_a_c;
   assign rf.RdDataB = rd_b_c;
   assign rf.WrErr   = wr_err_q;

endmodule
